serial_fft_reorder: RTL and testbench
=====================================

Name: serial_fft_reorder

Overview:
- Output-side companion of serial_fft. It consumes the FFT's serial result stream, which arrives in bit-reversed index order, one complex sample per cycle.
- It re-emits each frame in natural index order (X[0]..X[N-1]) with a last-sample marker.
- Two-bank ping-pong buffer: one frame is written while the previous one is read out.
- Sits directly on serial_fft's o_real/o_imag/o_valid and forwards to downstream consumers; there is no backpressure.

Parameters:
- NBD, 8, bit width of each real and imaginary component.
- NSIZES, 2, number of supported frame sizes. Size index s selects N = MAXSIZE >> s.
- MAXSIZE, 16, largest frame length; power of two ≥ 4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_sync  in  1  synchronous, active-high reset.
- i_size  in  $clog2(NSIZES)  frame-size index; sampled with the first accepted sample of each frame.
- i_real  in  NBD  real part of input sample (bit-reversed order).
- i_imag  in  NBD  imaginary part of input sample.
- i_valid  in  1  input sample strobe.
- o_real  out  NBD  real part, natural order.
- o_imag  out  NBD  imaginary part, natural order.
- o_valid  out  1  output sample strobe.
- o_last  out  1  high with X[N-1] of each frame.
- o_ovf  out  1  one-cycle pulse per dropped input sample.

Behaviour:
- Interface: one clock clk; reset rst_sync is synchronous and active-high.
- Reset (rst_sync=1 at an edge), including mid-frame or mid-readout:
  - o_valid, o_last, o_ovf = 0; o_real, o_imag = 0.
  - Write counter, both bank-full flags and bank pointers cleared; reader returns to IDLE.
  - Memory contents are not cleared; the partial frame and any pending bank are discarded.
- Write side:
  - Write counter wc counts 0..N-1 and holds between gaps (i_valid=0).
  - When wc=0 and the sample is accepted, i_size is latched as the frame size for that bank. i_size changes mid-frame are ignored.
  - Accepted sample k is written to the current write bank at address bitrev(k, log2 N), using only the low log2 N bits.
  - When k=N-1 is written, that bank's full flag sets, the bank's size is stored with it, wc returns to 0, and the write bank toggles.
- Overflow:
  - If i_valid=1 and the current write bank's full flag is set, the sample is dropped and o_ovf=1 for that cycle.
  - wc does not advance and the bank does not toggle. Writing resumes with the next valid sample after the flag clears.
- Read side FSM:
  - IDLE: if the full flag of read bank rb is set, go to READ with read counter rc=0.
  - READ: each cycle, register mem[rb][rc] onto o_real/o_imag with o_valid=1; o_last=1 when rc = N_rb-1.
  - On the last read: clear full[rb], toggle rb. If the other bank is already full, stay in READ with rc=0 (no gap between frames); otherwise go to IDLE.
- Latency:
  - X[0] is registered on the first edge after the edge that writes the frame's last sample. X[k] follows on the edge k later.
  - Readout is always N consecutive cycles, independent of input gaps.
- Same-cycle events:
  - A write completing into bank B while bank A issues its last read: both take effect, and the reader proceeds directly into B.
  - Full-flag clear by the reader takes priority for the write-side check in the following cycle only; writer and reader never access the same bank in one cycle.
- When o_valid=0: o_real, o_imag and o_last are 0.
- Memory: 2·MAXSIZE entries of 2·NBD bits, written synchronously and read into registered outputs.

Test Plan:
- i_size=0, continuous i_valid, i_real=bitrev4(i) for i=0..15, i_imag=15-bitrev4(i) → o_real=0..15 and o_imag=15..0 on 16 consecutive cycles starting one edge after the last input. o_last only on o_real=15. o_ovf never set.
- i_size=1, i_real=bitrev3(i) for i=0..7, with i_valid low every other cycle → o_real=0..7 on 8 consecutive cycles after the 8th accepted sample. i_size toggled to 0 mid-frame has no effect.
- Two back-to-back N=16 frames (values 0..15 then 16..31, bit-reversed order), continuous valid → 32 consecutive o_valid cycles, o_real=0..31, o_last at 15 and 31.
- Overflow: an N=16 frame, then two N=8 frames with continuous valid → second N=8 frame's first 8 samples dropped while bank A still reads out (o_ovf pulses 8 times, cycles 25..32). First N=8 frame is output intact right after the N=16 frame.
- Assert rst_sync mid-readout (after 5 outputs) → next edge o_valid=0 and outputs 0. A fresh N=16 frame afterwards reorders correctly with nominal latency.
- Reset mid-input (after 6 samples), then a full N=8 frame → only the new frame is output, with correct order.

Source files
------------

// File: rtl/serial_fft_reorder.sv
// Reorders serial_fft's bit-reversed result stream into natural index order
// using a two-bank ping-pong buffer; one frame is written while the other is read.
module serial_fft_reorder #(
  parameter int NBD     = 8,
  parameter int NSIZES  = 2,
  parameter int MAXSIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst_sync,
  input  logic [$clog2(NSIZES)-1:0] i_size,
  input  logic [NBD-1:0]            i_real,
  input  logic [NBD-1:0]            i_imag,
  input  logic                      i_valid,
  output logic [NBD-1:0]            o_real,
  output logic [NBD-1:0]            o_imag,
  output logic                      o_valid,
  output logic                      o_last,
  output logic                      o_ovf
);

  localparam int LW = $clog2(MAXSIZE);
  localparam int SW = $clog2(NSIZES);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LW-1:0] last_idx(input logic [SW-1:0] s);
    return LW'((MAXSIZE >> s) - 1);
  endfunction

  // Reverse all LW bits, then shift down so only the low log2(N) bits are reversed.
  function automatic logic [LW-1:0] rev_addr(input logic [LW-1:0] k, input logic [SW-1:0] s);
    logic [LW-1:0] r;
    r = {<<{k}};
    return r >> s;
  endfunction

  logic [2*NBD-1:0] mem [2*MAXSIZE];

  state_t          state_q;
  logic [LW-1:0]   wc_q, wc_d, rc_q;
  logic            wb_q, rb_q;
  logic [1:0]      full_q, full_d;
  logic [SW-1:0]   cur_size_q;
  logic [SW-1:0]   bank_size_q [2];
  logic [NBD-1:0]  o_real_q, o_imag_q;
  logic            o_valid_q, o_last_q, o_ovf_q;

  logic [SW-1:0]   wr_size;
  logic            wr_acc, wr_last;
  logic            rd_en, rd_last, rd_next_full;
  logic [2*NBD-1:0] rd_data;

  always_comb begin
    wr_size      = (wc_q == '0) ? i_size : cur_size_q;
    wr_acc       = i_valid && !full_q[wb_q];
    wr_last      = wr_acc && (wc_q == last_idx(wr_size));
    // IDLE issues X[0] in the same cycle it sees the full flag, keeping latency at one edge.
    rd_en        = (state_q == READ) || full_q[rb_q];
    rd_last      = rd_en && (rc_q == last_idx(bank_size_q[rb_q]));
    rd_next_full = full_q[~rb_q] || (wr_last && (wb_q != rb_q));
    rd_data      = mem[{rb_q, rc_q}];

    wc_d = wc_q;
    if (wr_last)     wc_d = '0;
    else if (wr_acc) wc_d = wc_q + 1'b1;

    full_d = full_q;
    if (rd_last) full_d[rb_q] = 1'b0;
    if (wr_last) full_d[wb_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wb_q, rev_addr(wc_q, wr_size)}] <= {i_real, i_imag};
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q        <= IDLE;
      wc_q           <= '0;
      rc_q           <= '0;
      wb_q           <= 1'b0;
      rb_q           <= 1'b0;
      full_q         <= '0;
      cur_size_q     <= '0;
      bank_size_q[0] <= '0;
      bank_size_q[1] <= '0;
      o_real_q       <= '0;
      o_imag_q       <= '0;
      o_valid_q      <= 1'b0;
      o_last_q       <= 1'b0;
      o_ovf_q        <= 1'b0;
    end else begin
      wc_q    <= wc_d;
      full_q  <= full_d;
      o_ovf_q <= i_valid && full_q[wb_q];
      if (wr_acc && (wc_q == '0)) cur_size_q <= i_size;
      if (wr_last) begin
        bank_size_q[wb_q] <= wr_size;
        wb_q              <= ~wb_q;
      end

      o_valid_q <= rd_en;
      o_last_q  <= rd_last;
      o_real_q  <= rd_en ? rd_data[2*NBD-1:NBD] : '0;
      o_imag_q  <= rd_en ? rd_data[NBD-1:0]     : '0;

      if (rd_en) begin
        if (rd_last) begin
          rb_q    <= ~rb_q;
          rc_q    <= '0;
          state_q <= rd_next_full ? READ : IDLE;
        end else begin
          rc_q    <= rc_q + 1'b1;
          state_q <= READ;
        end
      end
    end
  end

  assign o_real  = o_real_q;
  assign o_imag  = o_imag_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_serial_fft_reorder.sv
// Scoreboard bench for serial_fft_reorder: expected natural-order samples are queued
// as frames are driven and popped when the DUT emits them.
module tb_serial_fft_reorder;

  localparam int NBD = 8;

  logic           clk = 1'b0;
  logic           rst_sync;
  logic [0:0]     i_size;
  logic [NBD-1:0] i_real, i_imag;
  logic           i_valid;
  logic [NBD-1:0] o_real, o_imag;
  logic           o_valid, o_last, o_ovf;

  serial_fft_reorder #(.NBD(8), .NSIZES(2), .MAXSIZE(16)) dut (
    .clk(clk), .rst_sync(rst_sync), .i_size(i_size),
    .i_real(i_real), .i_imag(i_imag), .i_valid(i_valid),
    .o_real(o_real), .o_imag(o_imag), .o_valid(o_valid),
    .o_last(o_last), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NBD-1:0] re;
    logic [NBD-1:0] im;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   nvec = 0, nerr = 0;
  int   ovf_cnt = 0, run_len = 0, last_run = 0, ovf_base = 0;
  bit   mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++)
      if (((v >> b) & 1) != 0) r |= (1 << (bits - 1 - b));
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_ovf) ovf_cnt++;
      if (o_valid) begin
        run_len++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'(o_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("o_real", 32'(o_real), 32'(mon_e.re));
          check_eq("o_imag", 32'(o_imag), 32'(mon_e.im));
          check_eq("o_last", 32'(o_last), 32'(mon_e.last));
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        check_eq("idle_zero", 32'({o_real, o_imag, o_last}), 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [0:0] sz, input logic [NBD-1:0] re, input logic [NBD-1:0] im);
    i_valid = v; i_size = sz; i_real = re; i_imag = im;
    @(posedge clk); #1;
  endtask

  // Sends the first cnt samples of an n-point frame in bit-reversed order.
  task automatic send_frame(input int n, input int sz, input int base, input int cnt,
                            input bit gaps, input bit toggle, input bit push);
    int lg = 0;
    int idx;
    while ((1 << lg) < n) lg++;
    if (push)
      for (int j = 0; j < n; j++)
        exp_q.push_back('{re: NBD'(base + j), im: NBD'(base + n - 1 - j), last: (j == n - 1)});
    for (int i = 0; i < cnt; i++) begin
      idx = brev(i, lg);
      drive(1'b1, (toggle && i > 0) ? ~1'(sz) : 1'(sz), NBD'(base + idx), NBD'(base + n - 1 - idx));
      if (gaps && i < cnt - 1) drive(1'b0, 1'(sz), '0, '0);
    end
    i_valid = 1'b0;
  endtask

  task automatic lat_check();
    @(negedge clk);
    check_eq("pre_lat_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_valid", 32'(o_valid), 32'd1);
  endtask

  task automatic drain(input int exp_run);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    if (exp_run >= 0) check_eq("run_len", 32'(last_run), 32'(exp_run));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_sync = 1'b1; i_valid = 1'b0; i_size = '0; i_real = '0; i_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_ovf", 32'(o_ovf), 32'd0);
    check_eq("rst_data", 32'({o_real, o_imag, o_last}), 32'd0);
    rst_sync = 1'b0;
    mon_en = 1'b1;

    // N=16 continuous
    ovf_base = ovf_cnt;
    send_frame(16, 0, 0, 16, 1'b0, 1'b0, 1'b1);
    lat_check();
    drain(16);
    check_eq("ovf_none", 32'(ovf_cnt - ovf_base), 32'd0);

    // N=8 with gaps, i_size toggled after the first sample
    send_frame(8, 1, 0, 8, 1'b1, 1'b1, 1'b1);
    lat_check();
    drain(8);

    // two back-to-back N=16 frames
    send_frame(16, 0, 0, 16, 1'b0, 1'b0, 1'b1);
    send_frame(16, 0, 16, 16, 1'b0, 1'b0, 1'b1);
    drain(32);

    // overflow: N=16, N=8, then an N=8 frame that is fully dropped
    ovf_base = ovf_cnt;
    send_frame(16, 0, 0, 16, 1'b0, 1'b0, 1'b1);
    send_frame(8, 1, 40, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8, 1, 80, 8, 1'b0, 1'b0, 1'b0);
    drain(24);
    check_eq("ovf_count", 32'(ovf_cnt - ovf_base), 32'd8);

    // reset after five outputs of a readout
    send_frame(16, 0, 32, 16, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    exp_q.delete();
    rst_sync = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midread_rst_valid", 32'(o_valid), 32'd0);
    check_eq("midread_rst_data", 32'({o_real, o_imag, o_last}), 32'd0);
    rst_sync = 1'b0;
    send_frame(16, 0, 64, 16, 1'b0, 1'b0, 1'b1);
    lat_check();
    drain(16);

    // reset after six input samples, then a complete N=8 frame
    send_frame(8, 1, 100, 6, 1'b0, 1'b0, 1'b0);
    rst_sync = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    rst_sync = 1'b0;
    send_frame(8, 1, 120, 8, 1'b0, 1'b0, 1'b1);
    lat_check();
    drain(8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
